// File: rtl/xor_weight_counter_pkg.sv
// rtl/xor_weight_counter_pkg.sv - shared types and defaults for the XOR weight counter
package xor_weight_counter_pkg;

   localparam int WIDTH_DEF = 20;
   localparam int CW_DEF    = 5;
   localparam int ACC_W_DEF = 16;
   localparam int SAT_MAX   = (1 << ACC_W_DEF) - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/xor_weight_counter_if.sv
// rtl/xor_weight_counter_if.sv - difference-word input and weight/match result handshakes
interface xor_weight_counter_if
   import xor_weight_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CW    = CW_DEF
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] diff;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    weight;
   logic             match;

   modport master (
      output in_valid, diff, out_ready,
      input  in_ready, out_valid, weight, match
   );

   modport slave (
      input  in_valid, diff, out_ready,
      output in_ready, out_valid, weight, match
   );

endinterface

// File: rtl/xor_weight_counter_popcnt_shifter.sv
// rtl/xor_weight_counter_popcnt_shifter.sv - serial popcount, one bit per step
module xor_weight_counter_popcnt_shifter
   import xor_weight_counter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             last_o,
   output logic [CW-1:0]    count_o
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // count_o already includes the bit being consumed this step
   assign count_o = cnt_q + CW'(shreg_q[0]);
   assign last_o  = (idx_q == IW'(WIDTH - 1));

   always_comb begin
      shreg_d = shreg_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shreg_d = data_i;
         idx_d   = '0;
         cnt_d   = '0;
      end else if (step_i) begin
         shreg_d = shreg_q >> 1;
         idx_d   = idx_q + IW'(1);
         cnt_d   = count_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/xor_weight_counter.sv
// rtl/xor_weight_counter.sv - serial Hamming weight of XOR words with threshold flag and saturating total
module xor_weight_counter
   import xor_weight_counter_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CW     = CW_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int THRESH = 3
) (
   input  logic             clk,
   input  logic             rst,
   xor_weight_counter_if.slave bus,
   input  logic             clr,
   output logic [ACC_W-1:0] total
);

   localparam logic [ACC_W-1:0] SAT_LIM = '1;

   state_t state_q, state_d;

   logic          in_ready, out_valid;
   logic          load, step, last, done_hs;
   logic [CW-1:0] count;

   logic [CW-1:0]    weight_q, weight_d;
   logic             match_q, match_d;
   logic [ACC_W-1:0] total_q, total_d;
   logic [ACC_W:0]   sum;

   xor_weight_counter_popcnt_shifter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_shifter (
      .clk     (clk),
      .rst     (rst),
      .load_i  (load),
      .step_i  (step),
      .data_i  (bus.diff),
      .last_o  (last),
      .count_o (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.in_valid)  state_d = SHIFT;
         SHIFT:   if (last)          state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load      = 1'b0;
      step      = 1'b0;
      done_hs   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            load     = bus.in_valid;
         end
         SHIFT: step = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            done_hs   = bus.out_ready;
         end
         default: ;
      endcase
   end

   // widen by one bit so the carry out of the add marks saturation
   assign sum = {1'b0, total_q} + (ACC_W + 1)'(weight_q);

   always_comb begin
      weight_d = weight_q;
      match_d  = match_q;
      total_d  = total_q;
      if (step && last) begin
         weight_d = count;
         match_d  = (32'(count) <= THRESH);
      end
      if (clr) begin
         total_d = '0;
      end else if (done_hs) begin
         total_d = (sum > {1'b0, SAT_LIM}) ? SAT_LIM : sum[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         weight_q <= '0;
         match_q  <= 1'b0;
         total_q  <= '0;
      end else begin
         weight_q <= weight_d;
         match_q  <= match_d;
         total_q  <= total_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.weight    = weight_q;
   assign bus.match     = match_q;
   assign total         = total_q;

endmodule

// File: tb/tb_xor_weight_counter.sv
// tb/tb_xor_weight_counter.sv - directed self-checking bench for xor_weight_counter
module tb_xor_weight_counter;
   import xor_weight_counter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [15:0] total;

   xor_weight_counter_if bus ();

   xor_weight_counter dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus),
      .clr   (clr),
      .total (total)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_chk  = 0;
   int model_total = 0;

   typedef struct {
      logic [19:0] d;
      int          w;
      int          m;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int sat_add(input int a, input int b);
      return (a + b > SAT_MAX) ? SAT_MAX : a + b;
   endfunction

   // accept one word, wait for its result, then complete the output handshake
   task automatic run_word(input logic [19:0] d, output int lat, output int w, output int m);
      int guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      bus.in_valid = 1'b1;
      bus.diff     = d;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      w = int'(bus.weight);
      m = int'(bus.match);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int lat, w, m, w1, m1, w2, m2, cyc, stable, bad, rem;

      vecs[0] = '{20'h00001, 1, 1};
      vecs[1] = '{20'h00007, 3, 1};
      vecs[2] = '{20'h0000F, 4, 0};
      vecs[3] = '{20'h80000, 1, 1};
      vecs[4] = '{20'h12345, 7, 0};
      vecs[5] = '{20'hF0F0F, 12, 0};
      vecs[6] = '{20'h55555, 10, 0};
      vecs[7] = '{20'h00003, 2, 1};

      rst = 1'b1; clr = 1'b0;
      bus.in_valid = 1'b0; bus.diff = '0; bus.out_ready = 1'b0;
      #12;
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_weight", bus.weight, 0);
      check("reset_match", bus.match, 0);
      check("reset_total", total, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_in_ready", bus.in_ready, 1);

      // zero word: fixed 20-cycle latency
      run_word(20'h00000, lat, w, m);
      check("zero_latency", lat, 20);
      check("zero_weight", w, 0);
      check("zero_match", m, 1);
      check("zero_total", total, 0);

      // back-to-back words with out_ready held high
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.diff      = 20'hFFFFF;
      @(posedge clk); #1;
      bus.diff = 20'hA5A5A;
      cyc = 0; w1 = -1; m1 = -1;
      while (bus.in_ready !== 1'b1 && cyc < 60) begin
         @(posedge clk); #1; cyc++;
         if (bus.out_valid === 1'b1) begin w1 = int'(bus.weight); m1 = int'(bus.match); end
      end
      @(posedge clk); #1; cyc++;
      bus.in_valid = 1'b0;
      check("b2b_accept_period", cyc, 22);
      check("b2b_in_ready_low", bus.in_ready, 0);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      w2 = int'(bus.weight); m2 = int'(bus.match);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      model_total = sat_add(sat_add(model_total, 20), 10);
      check("b2b_w1", w1, 20);
      check("b2b_m1", m1, 0);
      check("b2b_latency2", lat, 20);
      check("b2b_w2", w2, 10);
      check("b2b_m2", m2, 0);
      check("b2b_total", total, model_total);

      // stalled consumer; an offered word must be ignored while busy
      bus.in_valid = 1'b1; bus.diff = 20'h80001;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("stall_latency", lat, 20);
      bus.in_valid = 1'b1; bus.diff = 20'hFFFFF;
      stable = 1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (!(bus.out_valid === 1'b1 && bus.weight == 5'd2 && bus.in_ready === 1'b0
               && total == 16'(model_total))) stable = 0;
      end
      check("stall_stable", stable, 1);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      model_total = sat_add(model_total, 2);
      check("stall_total", total, model_total);
      check("stall_out_valid_drop", bus.out_valid, 0);
      check("stall_back_idle", bus.in_ready, 1);

      for (int i = 0; i < 8; i++) begin
         run_word(vecs[i].d, lat, w, m);
         model_total = sat_add(model_total, vecs[i].w);
         check($sformatf("vec%0d_latency", i), lat, 20);
         check($sformatf("vec%0d_weight", i), w, vecs[i].w);
         check($sformatf("vec%0d_match", i), m, vecs[i].m);
         check($sformatf("vec%0d_total", i), total, model_total);
      end

      // clr coinciding with the output handshake wins over the add
      bus.in_valid = 1'b1; bus.diff = 20'h0007F;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("clr_weight7", bus.weight, 7);
      bus.out_ready = 1'b1; clr = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0; clr = 1'b0;
      model_total = 0;
      check("clr_total", total, 0);
      check("clr_fsm_idle", bus.in_ready, 1);
      run_word(20'h00007, lat, w, m);
      model_total = sat_add(model_total, 3);
      check("post_clr_weight", w, 3);
      check("post_clr_match", m, 1);
      check("post_clr_total", total, 3);

      // preload the total to 65530, then saturate
      bad = 0;
      while (model_total + 20 <= 65530) begin
         run_word(20'hFFFFF, lat, w, m);
         if (lat != 20 || w != 20) bad++;
         model_total = sat_add(model_total, 20);
      end
      rem = 65530 - model_total;
      run_word(20'((1 << rem) - 1), lat, w, m);
      model_total = sat_add(model_total, rem);
      check("preload_bad_words", bad, 0);
      check("preload_total", total, 65530);
      run_word(20'hFFFFF, lat, w, m);
      check("sat_weight", w, 20);
      check("sat_total", total, 65535);
      run_word(20'h00001, lat, w, m);
      check("sat_hold", total, 65535);

      // asynchronous reset in the middle of a count
      bus.in_valid = 1'b1; bus.diff = 20'hFFFFF;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_out_valid", bus.out_valid, 0);
      check("rst_mid_in_ready", bus.in_ready, 1);
      check("rst_mid_weight", bus.weight, 0);
      check("rst_mid_match", bus.match, 0);
      check("rst_mid_total", total, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_total = 0;
      stable = 1;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stable = 0;
      end
      check("rst_no_stale", stable, 1);
      run_word(20'h80001, lat, w, m);
      model_total = sat_add(model_total, 2);
      check("rst_next_latency", lat, 20);
      check("rst_next_weight", w, 2);
      check("rst_next_match", m, 1);
      check("rst_next_total", total, model_total);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
